// File: rtl/renkon_pkg.sv
// Shared parameters, FSM state type and saturation helper
// for the renkon convolution accelerator.
package renkon_pkg;

    localparam int DWIDTH  = 16;
    localparam int LWIDTH  = 10;
    localparam int IMGSIZE = 12;
    localparam int NETSIZE = 11;
    localparam int CORE    = 8;
    localparam int CORELOG = 3;
    localparam int FACT    = 8;
    localparam int FSIZE   = 5;
    localparam int PSIZE   = 2;
    localparam int AWIDTH  = 2 * DWIDTH + 8;

    typedef enum logic [2:0] {
        IDLE, MAC, BIAS, POOL, WRITE, DONE
    } state_t;

    localparam logic signed [AWIDTH-1:0] MAXV = AWIDTH'(2 ** (DWIDTH - 1) - 1);
    localparam logic signed [AWIDTH-1:0] MINV = ~MAXV;

    function automatic logic signed [DWIDTH-1:0] sat_dw(
        input logic signed [AWIDTH-1:0] v
    );
        if (v > MAXV)
            sat_dw = MAXV[DWIDTH-1:0];
        else if (v < MINV)
            sat_dw = MINV[DWIDTH-1:0];
        else
            sat_dw = v[DWIDTH-1:0];
    endfunction

endpackage

// File: rtl/renkon_pe.sv
// One processing element: weight memory, MAC, bias+saturate,
// ReLU and running pool max.
// Ports: clk/xrst; i_we/i_waddr/i_wdata host weight write;
//   i_raddr weight read address (1-cycle latency); i_pix
//   broadcast pixel; i_mac accumulate; i_fin finalize with
//   bias (weight read data holds the bias); i_first first
//   pool element; o_pool pooled result.
module renkon_pe
    import renkon_pkg::*;
(
    input  logic                      clk,
    input  logic                      xrst,
    input  logic                      i_we,
    input  logic [NETSIZE-1:0]        i_waddr,
    input  logic signed [DWIDTH-1:0]  i_wdata,
    input  logic [NETSIZE-1:0]        i_raddr,
    input  logic signed [DWIDTH-1:0]  i_pix,
    input  logic                      i_mac,
    input  logic                      i_fin,
    input  logic                      i_first,
    output logic signed [DWIDTH-1:0]  o_pool
);

    logic signed [DWIDTH-1:0]   r_mem [2**NETSIZE];
    logic signed [DWIDTH-1:0]   r_w;
    logic signed [AWIDTH-1:0]   r_acc;
    logic signed [DWIDTH-1:0]   r_pool;
    logic signed [2*DWIDTH-1:0] w_prod;
    logic signed [AWIDTH-1:0]   w_sum;
    logic signed [DWIDTH-1:0]   w_v;
    logic signed [DWIDTH-1:0]   w_relu;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        r_w <= r_mem[i_raddr];
    end

    assign w_prod = (2*DWIDTH)'(i_pix) * (2*DWIDTH)'(r_w);
    // r_w carries the bias word during finalize
    assign w_sum  = (r_acc >>> FACT) + AWIDTH'(r_w);
    assign w_v    = sat_dw(w_sum);
    assign w_relu = w_v[DWIDTH-1] ? '0 : w_v;

    always_ff @(posedge clk) begin
        if (xrst) begin
            r_acc  <= '0;
            r_pool <= '0;
        end else if (i_fin) begin
            r_acc <= '0;
            if (i_first || w_relu > r_pool)
                r_pool <= w_relu;
        end else if (i_mac) begin
            r_acc <= r_acc + AWIDTH'(w_prod);
        end
    end

    assign o_pool = r_pool;

endmodule

// File: rtl/renkon_top.sv
// Conv/bias/ReLU/max-pool accelerator: image memory, address
// counters and FSM driving CORE parallel PEs.
// Ports: clk/xrst; req start; img_we/input_addr/write_img and
//   net_we/net_addr/write_net host access; output_addr and
//   total_out/total_in/img_size/fil_size/pool_size layer setup;
//   ack done; read_img registered image read data.
module renkon_top
    import renkon_pkg::*;
(
    input  logic                      clk,
    input  logic                      xrst,
    input  logic                      req,
    input  logic                      img_we,
    input  logic [IMGSIZE-1:0]        input_addr,
    input  logic [IMGSIZE-1:0]        output_addr,
    input  logic signed [DWIDTH-1:0]  write_img,
    input  logic [CORELOG:0]          net_we,
    input  logic [NETSIZE-1:0]        net_addr,
    input  logic signed [DWIDTH-1:0]  write_net,
    input  logic [LWIDTH-1:0]         total_out,
    input  logic [LWIDTH-1:0]         total_in,
    input  logic [LWIDTH-1:0]         img_size,
    input  logic [LWIDTH-1:0]         fil_size,
    input  logic [LWIDTH-1:0]         pool_size,
    output logic                      ack,
    output logic signed [DWIDTH-1:0]  read_img
);

    localparam logic [LWIDTH-1:0] ONE = LWIDTH'(1);

    state_t r_state, w_next;

    logic [LWIDTH-1:0]  r_tout, r_tin, r_isz, r_fsz, r_psz;
    logic [LWIDTH-1:0]  r_osz, r_gcnt;
    logic [IMGSIZE-1:0] r_ib, r_ob;
    logic [NETSIZE-1:0] r_nb;
    logic [31:0]        r_wlen, r_wbase, r_widx;
    logic [LWIDTH-1:0]  r_g, r_py, r_px, r_i, r_j;
    logic [LWIDTH-1:0]  r_m, r_ky, r_kx;
    logic [CORELOG-1:0] r_wc;
    logic               r_vld, r_ack;
    logic signed [DWIDTH-1:0] r_rd;
    logic signed [DWIDTH-1:0] r_mem [2**IMGSIZE];

    logic w_idle, w_first;
    logic w_kx_last, w_ky_last, w_m_last, w_mac_last;
    logic w_j_last, w_i_last, w_pe_last;
    logic w_wc_last, w_px_last, w_py_last, w_g_last;
    logic [31:0]        w_y, w_x, w_c;
    logic [IMGSIZE-1:0] w_paddr, w_oaddr, w_raddr;
    logic [NETSIZE-1:0] w_waddr;
    logic               w_owe, w_iwe;
    logic [IMGSIZE-1:0] w_iwaddr;
    logic signed [DWIDTH-1:0] w_iwdata;
    logic signed [DWIDTH-1:0] w_pool [CORE];

    assign w_idle     = (r_state == IDLE);
    assign w_kx_last  = (r_kx == r_fsz - ONE);
    assign w_ky_last  = (r_ky == r_fsz - ONE);
    assign w_m_last   = (r_m == r_tin - ONE);
    assign w_mac_last = w_kx_last && w_ky_last && w_m_last;
    assign w_j_last   = (r_j == r_psz - ONE);
    assign w_i_last   = (r_i == r_psz - ONE);
    assign w_pe_last  = w_j_last && w_i_last;
    assign w_first    = (r_i == '0) && (r_j == '0);
    assign w_wc_last  = (r_wc == '1);
    assign w_px_last  = (r_px == r_osz - ONE);
    assign w_py_last  = (r_py == r_osz - ONE);
    assign w_g_last   = (r_g == r_gcnt - ONE);

    assign w_y = 32'(r_py) * 32'(r_psz) + 32'(r_i) + 32'(r_ky);
    assign w_x = 32'(r_px) * 32'(r_psz) + 32'(r_j) + 32'(r_kx);
    assign w_paddr = IMGSIZE'(32'(r_ib)
                   + 32'(r_m) * 32'(r_isz) * 32'(r_isz)
                   + w_y * 32'(r_isz) + w_x);
    // bias sits right after the W weights of the group
    assign w_waddr = NETSIZE'(32'(r_nb) + r_wbase
                   + ((r_state == BIAS) ? r_wlen : r_widx));
    assign w_c     = 32'(r_g) * 32'(CORE) + 32'(r_wc);
    assign w_oaddr = IMGSIZE'(32'(r_ob)
                   + w_c * 32'(r_osz) * 32'(r_osz)
                   + 32'(r_py) * 32'(r_osz) + 32'(r_px));
    assign w_owe   = (r_state == WRITE) && (w_c < 32'(r_tout));

    assign w_iwe    = (w_idle && img_we) || w_owe;
    assign w_iwaddr = w_idle ? input_addr : w_oaddr;
    assign w_iwdata = w_idle ? write_img : w_pool[r_wc];
    assign w_raddr  = w_idle ? input_addr : w_paddr;

    always_ff @(posedge clk) begin
        if (w_iwe)
            r_mem[w_iwaddr] <= w_iwdata;
    end

    always_ff @(posedge clk) begin
        if (xrst)
            r_rd <= '0;
        else
            r_rd <= r_mem[w_raddr];
    end

    for (genvar k = 0; k < CORE; k++) begin : g_pe
        renkon_pe u_pe (
            .clk     (clk),
            .xrst    (xrst),
            .i_we    (w_idle && (net_we == (CORELOG+1)'(k + 1))),
            .i_waddr (net_addr),
            .i_wdata (write_net),
            .i_raddr (w_waddr),
            .i_pix   (r_rd),
            .i_mac   (r_vld),
            .i_fin   (r_state == POOL),
            .i_first (w_first),
            .o_pool  (w_pool[k])
        );
    end

    always_ff @(posedge clk) begin
        if (xrst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (req) w_next = MAC;
            MAC:   if (w_mac_last) w_next = BIAS;
            BIAS:  w_next = POOL;
            POOL:  w_next = w_pe_last ? WRITE : MAC;
            WRITE: if (w_wc_last)
                       w_next = (w_px_last && w_py_last && w_g_last)
                              ? DONE : MAC;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (xrst) begin
            r_ack   <= 1'b0;
            r_vld   <= 1'b0;
            r_tout  <= '0;
            r_tin   <= '0;
            r_isz   <= '0;
            r_fsz   <= '0;
            r_psz   <= '0;
            r_osz   <= '0;
            r_gcnt  <= '0;
            r_ib    <= '0;
            r_ob    <= '0;
            r_nb    <= '0;
            r_wlen  <= '0;
            r_wbase <= '0;
            r_widx  <= '0;
            r_g     <= '0;
            r_py    <= '0;
            r_px    <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_m     <= '0;
            r_ky    <= '0;
            r_kx    <= '0;
            r_wc    <= '0;
        end else begin
            // read data lags the issued address by one cycle
            r_vld <= (r_state == MAC);
            unique case (r_state)
                IDLE: begin
                    if (req) begin
                        r_ack   <= 1'b0;
                        r_tout  <= total_out;
                        r_tin   <= total_in;
                        r_isz   <= img_size;
                        r_fsz   <= fil_size;
                        r_psz   <= pool_size;
                        r_osz   <= (img_size - fil_size + ONE) / pool_size;
                        r_gcnt  <= LWIDTH'((11'(total_out) + 11'(CORE - 1))
                                   >> CORELOG);
                        r_ib    <= input_addr;
                        r_ob    <= output_addr;
                        r_nb    <= net_addr;
                        r_wlen  <= 32'(total_in) * 32'(fil_size)
                                 * 32'(fil_size);
                        r_wbase <= '0;
                        r_widx  <= '0;
                        r_g     <= '0;
                        r_py    <= '0;
                        r_px    <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_m     <= '0;
                        r_ky    <= '0;
                        r_kx    <= '0;
                        r_wc    <= '0;
                    end
                end
                MAC: begin
                    r_widx <= r_widx + 32'd1;
                    if (w_kx_last) begin
                        r_kx <= '0;
                        if (w_ky_last) begin
                            r_ky <= '0;
                            r_m  <= w_m_last ? '0 : r_m + ONE;
                        end else begin
                            r_ky <= r_ky + ONE;
                        end
                    end else begin
                        r_kx <= r_kx + ONE;
                    end
                end
                BIAS: begin
                end
                POOL: begin
                    r_widx <= '0;
                    if (w_j_last) begin
                        r_j <= '0;
                        r_i <= w_i_last ? '0 : r_i + ONE;
                    end else begin
                        r_j <= r_j + ONE;
                    end
                end
                WRITE: begin
                    r_wc <= r_wc + CORELOG'(1);
                    if (w_wc_last) begin
                        if (w_px_last) begin
                            r_px <= '0;
                            if (w_py_last) begin
                                r_py    <= '0;
                                r_g     <= r_g + ONE;
                                r_wbase <= r_wbase + r_wlen + 32'd1;
                            end else begin
                                r_py <= r_py + ONE;
                            end
                        end else begin
                            r_px <= r_px + ONE;
                        end
                    end
                end
                DONE: r_ack <= 1'b1;
                default: begin
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign read_img = r_rd;

endmodule

// File: tb/tb_renkon_top.sv
// Self-checking bench for renkon_top: vector table for
// single-pixel arithmetic, scoreboard for whole layers.
module tb_renkon_top;
    import renkon_pkg::*;

    logic clk = 1'b0;
    logic xrst, req, img_we;
    logic [IMGSIZE-1:0] input_addr, output_addr;
    logic signed [DWIDTH-1:0] write_img, write_net;
    logic [CORELOG:0] net_we;
    logic [NETSIZE-1:0] net_addr;
    logic [LWIDTH-1:0] total_out, total_in, img_size, fil_size, pool_size;
    logic ack;
    logic signed [DWIDTH-1:0] read_img;

    always #5 clk = ~clk;

    renkon_top dut (
        .clk(clk), .xrst(xrst), .req(req), .img_we(img_we),
        .input_addr(input_addr), .output_addr(output_addr),
        .write_img(write_img), .net_we(net_we), .net_addr(net_addr),
        .write_net(write_net), .total_out(total_out),
        .total_in(total_in), .img_size(img_size),
        .fil_size(fil_size), .pool_size(pool_size),
        .ack(ack), .read_img(read_img)
    );

    int checks = 0;
    int errors = 0;

    logic signed [15:0] img_m [4096];
    logic signed [15:0] net_m [CORE][2048];

    typedef struct {
        int          addr;
        logic [15:0] data;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [15:0] pix;
        logic [15:0] w;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;
    vec_t tab[8];

    logic [15:0] d;

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rnd(int span);
        int v;
        v = int'($urandom_range(2 * span, 0)) - span;
        return 16'(v);
    endfunction

    task automatic wr_img(int a, logic [15:0] dat);
        @(negedge clk);
        input_addr = 12'(a);
        write_img  = dat;
        img_we     = 1'b1;
        @(posedge clk);
        #1 img_we = 1'b0;
        img_m[a % 4096] = dat;
    endtask

    task automatic wr_net(int core, int a, logic [15:0] dat);
        @(negedge clk);
        net_addr  = 11'(a);
        write_net = dat;
        net_we    = 4'(core + 1);
        @(posedge clk);
        #1 net_we = '0;
        net_m[core][a % 2048] = dat;
    endtask

    task automatic rd(int a, output logic [15:0] dat);
        @(negedge clk);
        input_addr = 12'(a);
        @(posedge clk);
        #1 dat = read_img;
    endtask

    task automatic start(int tin, int tout, int isz, int fsz, int psz,
                         int ib, int ob, int nb);
        @(negedge clk);
        total_in    = 10'(tin);
        total_out   = 10'(tout);
        img_size    = 10'(isz);
        fil_size    = 10'(fsz);
        pool_size   = 10'(psz);
        input_addr  = 12'(ib);
        output_addr = 12'(ob);
        net_addr    = 11'(nb);
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        check("ack_clr", 16'(ack), 16'h0);
    endtask

    task automatic wait_ack(string name);
        int n = 0;
        while (!ack && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 16'(ack), 16'h1);
    endtask

    task automatic drain(string name);
        exp_t e;
        logic [15:0] got;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rd(e.addr, got);
            check(name, got, e.data);
            img_m[e.addr] = e.data;
        end
    endtask

    task automatic model(int tin, int tout, int isz, int fsz, int psz,
                         int ib, int ob, int nb);
        int o, w, g, dn, base, y, x;
        longint acc, v, best;
        o = (isz - fsz + 1) / psz;
        w = tin * fsz * fsz;
        for (int c = 0; c < tout; c++) begin
            g = c / CORE;
            dn = c % CORE;
            base = nb + g * (w + 1);
            for (int py = 0; py < o; py++) begin
                for (int px = 0; px < o; px++) begin
                    best = 0;
                    for (int i = 0; i < psz; i++) begin
                        for (int j = 0; j < psz; j++) begin
                            y = py * psz + i;
                            x = px * psz + j;
                            acc = 0;
                            for (int m = 0; m < tin; m++)
                                for (int ky = 0; ky < fsz; ky++)
                                    for (int kx = 0; kx < fsz; kx++)
                                        acc += longint'(img_m[(ib + m*isz*isz
                                              + (y+ky)*isz + x + kx) % 4096])
                                             * longint'(net_m[dn][(base
                                              + m*fsz*fsz + ky*fsz + kx) % 2048]);
                            v = (acc >>> 8)
                              + longint'(net_m[dn][(base + w) % 2048]);
                            if (v > 32767) v = 32767;
                            if (v < -32768) v = -32768;
                            if (v < 0) v = 0;
                            if ((i == 0 && j == 0) || v > best)
                                best = v;
                        end
                    end
                    sbq.push_back('{(ob + c*o*o + py*o + px) % 4096,
                                    16'(best)});
                end
            end
        end
    endtask

    task automatic load_rand(int tin, int tout, int isz, int fsz,
                             int ib, int nb);
        int w;
        w = tin * fsz * fsz;
        for (int k = 0; k < tin * isz * isz; k++)
            wr_img(ib + k, rnd(16'h200));
        for (int c = 0; c < tout; c++)
            for (int k = 0; k <= w; k++)
                wr_net(c % CORE, nb + (c / CORE) * (w + 1) + k, rnd(16'h100));
    endtask

    task automatic run_layer(int tin, int tout, int isz, int fsz, int psz,
                             int ib, int ob, int nb, bit poke);
        int o, sa;
        o  = (isz - fsz + 1) / psz;
        sa = (ob + tout * o * o) % 4096;
        wr_img(sa, 16'h5A5A);
        model(tin, tout, isz, fsz, psz, ib, ob, nb);
        sbq.push_back('{sa, 16'h5A5A});
        start(tin, tout, isz, fsz, psz, ib, ob, nb);
        if (poke) begin
            @(negedge clk);
            input_addr = 12'(sa);
            write_img  = 16'hDEAD;
            img_we     = 1'b1;
            @(posedge clk);
            #1 img_we = 1'b0;
        end
        wait_ack("done");
        drain("out");
    endtask

    initial begin
        tab = '{
            '{16'h0100, 16'h0100, 16'h0000, 16'h0100},
            '{16'hFD00, 16'h0100, 16'h0000, 16'h0000},
            '{16'h7F00, 16'h0200, 16'h0000, 16'h7FFF},
            '{16'h0200, 16'h0180, 16'h0010, 16'h0310},
            '{16'h0100, 16'h0100, 16'hFE00, 16'h0000},
            '{16'hFFFF, 16'h0001, 16'h0005, 16'h0004},
            '{16'h8000, 16'h8000, 16'h0000, 16'h7FFF},
            '{16'h0100, 16'h0100, 16'h7FFF, 16'h7FFF}
        };
        xrst = 1'b1; req = 1'b0; img_we = 1'b0; net_we = '0;
        input_addr = '0; output_addr = '0; net_addr = '0;
        write_img = '0; write_net = '0;
        total_out = '0; total_in = '0; img_size = '0;
        fil_size = '0; pool_size = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 16'(ack), 16'h0);
        check("rst_rd", read_img, 16'h0);
        @(negedge clk);
        xrst = 1'b0;

        wr_img(5, 16'h1234);
        rd(5, d);
        check("host_rd", d, 16'h1234);
        wr_net(2, 0, 16'h0100);

        for (int k = 0; k < 8; k++) begin
            wr_img(100, tab[k].pix);
            wr_net(0, 0, tab[k].w);
            wr_net(0, 1, tab[k].b);
            start(1, 1, 1, 1, 1, 100, 200 + k, 0);
            wait_ack("vec_done");
            rd(200 + k, d);
            check($sformatf("vec%0d", k), d, tab[k].exp);
        end

        for (int k = 0; k < 4; k++)
            wr_img(300 + k, 16'((k + 1) << 8));
        wr_net(0, 0, 16'h0100);
        wr_net(0, 1, 16'h0000);
        run_layer(1, 1, 2, 1, 1, 300, 400, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1 check("ack_hold", 16'(ack), 16'h1);

        load_rand(1, 1, 4, 1, 500, 0);
        wr_net(0, 0, 16'h0100);
        wr_net(0, 1, 16'h0000);
        run_layer(1, 1, 4, 1, 2, 500, 600, 0, 1'b0);

        load_rand(1, 10, 2, 1, 700, 0);
        run_layer(1, 10, 2, 1, 1, 700, 800, 0, 1'b1);

        load_rand(4, 12, 8, FSIZE, 0, 0);
        start(4, 12, 8, FSIZE, PSIZE, 0, 3000, 0);
        repeat (50) @(posedge clk);
        @(negedge clk);
        xrst = 1'b1;
        @(posedge clk);
        #1 check("abort_ack", 16'(ack), 16'h0);
        @(negedge clk);
        xrst = 1'b0;
        wr_img(5, 16'hBEEF);
        rd(5, d);
        check("abort_idle", d, 16'hBEEF);

        run_layer(4, 12, 8, FSIZE, PSIZE, 0, 3000, 0, 1'b0);
        run_layer(4, 12, 8, FSIZE, PSIZE, 0, 3000, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
